// File: rtl/button_event_scheduler_if.sv
// Event-stream bundle between the button scheduler and its consumer.
// The master side is the scheduler; the slave side drives buttons and ready.
interface button_event_scheduler_if #(
   parameter int ID_W = 2
);
   localparam int N = 2 ** ID_W;

   logic [N-1:0]    btn_db;
   logic            ev_ready;
   logic            ev_valid;
   logic [ID_W-1:0] ev_id;
   logic [1:0]      ev_type;
   logic [2:0]      fifo_count;
   logic            overflow;

   modport master (
      input  btn_db,
      input  ev_ready,
      output ev_valid,
      output ev_id,
      output ev_type,
      output fifo_count,
      output overflow
   );

   modport slave (
      output btn_db,
      output ev_ready,
      input  ev_valid,
      input  ev_id,
      input  ev_type,
      input  fifo_count,
      input  overflow
   );
endinterface

// File: rtl/button_event_scheduler.sv
// Classifies debounced buttons into PRESS/LONG/REPEAT/RELEASE events and
// serialises them round-robin through a 4-deep show-ahead FIFO.
module button_event_scheduler #(
   parameter int ID_W       = 2,
   parameter int CNT_W      = 16,
   parameter int LONG_CNT   = 50000,
   parameter int REPEAT_CNT = 20000
) (
   input logic clk,
   input logic rst,
   button_event_scheduler_if.master ev_if
);
   localparam int N = 2 ** ID_W;

   typedef enum logic [1:0] {IDLE, DOWN, HELD} btnState_e;
   typedef enum logic [1:0] {EV_PRESS = 2'd0, EV_LONG = 2'd1, EV_REPEAT = 2'd2, EV_RELEASE = 2'd3} evType_e;

   btnState_e        state_q [N];
   btnState_e        state_d [N];
   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];
   logic [N-1:0]     emitValid;
   evType_e          emitType [N];

   logic [N-1:0]     slotValid_q;
   logic [1:0]       slotType_q [N];
   logic [ID_W-1:0]  rrPtr_q;

   logic [ID_W+1:0]  fifoMem_q [4];
   logic [1:0]       rdPtr_q;
   logic [1:0]       wrPtr_q;
   logic [2:0]       count_q;
   logic             overflow_q;

   logic             pop;
   logic             canPush;
   logic             grantValid;
   logic [ID_W-1:0]  grantId;
   logic [ID_W-1:0]  scanIdx;
   logic [N-1:0]     grantMask;

   // A release always wins over a threshold reached on the same edge.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         state_d[i]   = state_q[i];
         cnt_d[i]     = cnt_q[i];
         emitValid[i] = 1'b0;
         emitType[i]  = EV_PRESS;
         case (state_q[i])
            IDLE: begin
               if (ev_if.btn_db[i]) begin
                  state_d[i]   = DOWN;
                  cnt_d[i]     = '0;
                  emitValid[i] = 1'b1;
                  emitType[i]  = EV_PRESS;
               end
            end
            DOWN: begin
               if (!ev_if.btn_db[i]) begin
                  state_d[i]   = IDLE;
                  cnt_d[i]     = '0;
                  emitValid[i] = 1'b1;
                  emitType[i]  = EV_RELEASE;
               end else if (cnt_q[i] == CNT_W'(LONG_CNT - 1)) begin
                  state_d[i]   = HELD;
                  cnt_d[i]     = '0;
                  emitValid[i] = 1'b1;
                  emitType[i]  = EV_LONG;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            HELD: begin
               if (!ev_if.btn_db[i]) begin
                  state_d[i]   = IDLE;
                  cnt_d[i]     = '0;
                  emitValid[i] = 1'b1;
                  emitType[i]  = EV_RELEASE;
               end else if (cnt_q[i] == CNT_W'(REPEAT_CNT - 1)) begin
                  cnt_d[i]     = '0;
                  emitValid[i] = 1'b1;
                  emitType[i]  = EV_REPEAT;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // A full FIFO still accepts a push when its head is popped on the same edge.
   always_comb begin
      pop        = (count_q != 3'd0) && ev_if.ev_ready;
      canPush    = (count_q < 3'd4) || pop;
      grantValid = 1'b0;
      grantId    = '0;
      scanIdx    = '0;
      for (int k = 0; k < N; k++) begin
         scanIdx = rrPtr_q + ID_W'(k);
         if (!grantValid && slotValid_q[scanIdx] && canPush) begin
            grantValid = 1'b1;
            grantId    = scanIdx;
         end
      end
      grantMask = grantValid ? (N'(1) << grantId) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            state_q[i]    <= IDLE;
            cnt_q[i]      <= '0;
            slotType_q[i] <= '0;
         end
         for (int j = 0; j < 4; j++) begin
            fifoMem_q[j] <= '0;
         end
         slotValid_q <= '0;
         rrPtr_q     <= '0;
         rdPtr_q     <= '0;
         wrPtr_q     <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            if (emitValid[i]) begin
               if (slotValid_q[i] && !grantMask[i]) begin
                  overflow_q <= 1'b1;
               end else begin
                  slotValid_q[i] <= 1'b1;
                  slotType_q[i]  <= emitType[i];
               end
            end else if (grantMask[i]) begin
               slotValid_q[i] <= 1'b0;
            end
         end
         if (grantValid) begin
            fifoMem_q[wrPtr_q] <= {grantId, slotType_q[grantId]};
            wrPtr_q            <= wrPtr_q + 2'd1;
            rrPtr_q            <= grantId + ID_W'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 2'd1;
         end
         if (grantValid && !pop) begin
            count_q <= count_q + 3'd1;
         end else if (!grantValid && pop) begin
            count_q <= count_q - 3'd1;
         end
      end
   end

   assign ev_if.ev_valid   = (count_q != 3'd0);
   assign ev_if.ev_id      = ev_if.ev_valid ? fifoMem_q[rdPtr_q][ID_W+1:2] : '0;
   assign ev_if.ev_type    = ev_if.ev_valid ? fifoMem_q[rdPtr_q][1:0] : 2'd0;
   assign ev_if.fifo_count = count_q;
   assign ev_if.overflow   = overflow_q;

endmodule
